// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// constants, ALU operand-select codes and the instruction-class decode result.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IMM     = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_JUMP    = 3'd5,
        CLS_ILLEGAL = 3'd6
    } op_class_t;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_IMM_12 = 6'h12;
    localparam logic [5:0] OP_IMM_13 = 6'h13;
    localparam logic [5:0] OP_IMM_15 = 6'h15;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_LL     = 6'h30;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam logic [5:0] ALU_OP_RTYPE = 6'h00;
    localparam logic [5:0] ALU_OP_ADDIU = 6'h09;

    localparam logic [1:0] SRC_B_RT     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR   = 2'd1;
    localparam logic [1:0] SRC_B_IMM    = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

    localparam logic SRC_A_PC = 1'b0;
    localparam logic SRC_A_RS = 1'b1;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    function automatic logic funct_supported(input logic [5:0] f);
        case (f)
            FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_NOR, FN_SLT, FN_SLTU: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: opcode/funct -> instruction class and legality.
module mips_mc_decode
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output op_class_t  o_class,
    output logic       o_legal
);

    always_comb begin
        o_class = CLS_ILLEGAL;
        case (i_opcode)
            OP_RTYPE:                          o_class = CLS_R;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_IMM_12, OP_IMM_13, OP_IMM_15:   o_class = CLS_IMM;
            OP_LW, OP_LBU, OP_LHU, OP_LL:      o_class = CLS_LOAD;
            OP_SB, OP_SH, OP_SW:               o_class = CLS_STORE;
            OP_BEQ, OP_BNE:                    o_class = CLS_BRANCH;
            OP_J:                              o_class = CLS_JUMP;
            default:                           o_class = CLS_ILLEGAL;
        endcase
        o_legal = (o_class != CLS_ILLEGAL) &&
                  ((o_class != CLS_R) || funct_supported(i_funct));
    end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with a bounded memory handshake and trap handling.
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        sig_branch,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [5:0]  alu_opcode,
    output logic [5:0]  alu_control,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic        mem_err,
    output logic [3:0]  state
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait;
    logic [3:0] w_wait_next;
    logic       r_active;
    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    op_class_t  w_class;
    logic       w_legal;
    logic       w_in_mem;
    logic       w_timeout;
    logic       w_unused_bits;

    assign w_opcode      = instr[31:26];
    assign w_funct       = instr[5:0];
    assign w_unused_bits = ^instr[25:6];
    assign state         = r_state;

    mips_mc_decode u_decode (
        .i_opcode (w_opcode),
        .i_funct  (w_funct),
        .o_class  (w_class),
        .o_legal  (w_legal)
    );

    assign w_in_mem  = is_mem_state(r_state);
    assign w_timeout = w_in_mem && (r_wait == WAIT_LIMIT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_timeout)      w_next = S_FETCH;
                else if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                case (w_class)
                    CLS_R:                w_next = S_EXEC_R;
                    CLS_IMM:              w_next = S_EXEC_I;
                    CLS_LOAD, CLS_STORE:  w_next = S_MEM_ADDR;
                    CLS_BRANCH:           w_next = S_BRANCH;
                    CLS_JUMP:             w_next = S_JUMP;
                    default:              w_next = S_TRAP;
                endcase
            end
            S_EXEC_R:   w_next = w_legal ? S_WB_R : S_TRAP;
            S_EXEC_I:   w_next = S_WB_I;
            S_MEM_ADDR: w_next = (w_class == CLS_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (w_timeout)      w_next = S_FETCH;
                else if (mem_ready) w_next = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (w_timeout || mem_ready) w_next = S_FETCH;
            end
            default:    w_next = S_FETCH;
        endcase
    end

    // The counter only advances while stalled in a memory state, so any
    // completion, abort or non-memory state leaves it cleared for the next entry.
    always_comb begin
        w_wait_next = '0;
        if (w_in_mem && !w_timeout && !mem_ready)
            w_wait_next = r_wait + 4'd1;
    end

    // r_active holds the FSM idle (outputs low) until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_wait   <= '0;
            r_active <= 1'b0;
        end else if (!r_active) begin
            r_active <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_wait   <= w_wait_next;
        end
    end

    always_comb begin
        mem_req     = '0;
        mem_we      = '0;
        iord        = '0;
        ir_write    = '0;
        pc_write    = '0;
        reg_write   = '0;
        alu_src_a   = '0;
        alu_src_b   = '0;
        alu_opcode  = '0;
        alu_control = '0;
        reg_dst     = '0;
        mem_to_reg  = '0;
        pc_source   = '0;
        illegal_op  = '0;
        mem_err     = '0;
        if (r_active) begin
            if (w_timeout) begin
                mem_err = 1'b1;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        mem_req    = 1'b1;
                        alu_src_a  = SRC_A_PC;
                        alu_src_b  = SRC_B_FOUR;
                        alu_opcode = ALU_OP_ADDIU;
                        ir_write   = mem_ready;
                        pc_write   = mem_ready;
                    end
                    S_DECODE: begin
                        alu_src_a  = SRC_A_PC;
                        alu_src_b  = SRC_B_IMM_SH;
                        alu_opcode = ALU_OP_ADDIU;
                    end
                    S_EXEC_R: begin
                        alu_opcode  = ALU_OP_RTYPE;
                        alu_control = w_funct;
                        alu_src_a   = SRC_A_RS;
                        alu_src_b   = SRC_B_RT;
                    end
                    S_EXEC_I, S_MEM_ADDR: begin
                        alu_opcode = w_opcode;
                        alu_src_a  = SRC_A_RS;
                        alu_src_b  = SRC_B_IMM;
                    end
                    S_MEM_RD: begin
                        mem_req = 1'b1;
                        iord    = 1'b1;
                    end
                    S_MEM_WR: begin
                        mem_req = 1'b1;
                        iord    = 1'b1;
                        mem_we  = 1'b1;
                    end
                    S_WB_R: begin
                        reg_write = 1'b1;
                        reg_dst   = 1'b1;
                    end
                    S_WB_I: begin
                        reg_write = 1'b1;
                    end
                    S_WB_MEM: begin
                        reg_write  = 1'b1;
                        mem_to_reg = 1'b1;
                    end
                    S_BRANCH: begin
                        alu_opcode = w_opcode;
                        alu_src_a  = SRC_A_RS;
                        alu_src_b  = SRC_B_RT;
                        pc_source  = PC_SRC_ALUOUT;
                        pc_write   = sig_branch;
                    end
                    S_JUMP: begin
                        pc_source = PC_SRC_JUMP;
                        pc_write  = 1'b1;
                    end
                    S_TRAP: begin
                        illegal_op = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, 15, maximum wait cycles for mem_ready before abort.
REQ-002 SHALL have port clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port instr  input  32  instruction register contents (opcode [31:26], funct [5:0]).
REQ-005 SHALL have port sig_branch  input  1  ALU branch-taken flag.
REQ-006 SHALL have port mem_ready  input  1  memory completion strobe.
REQ-007 SHALL have port mem_req / mem_we / iord  output  1 each  memory request, write enable, data-address select (0 = PC).
REQ-008 SHALL have port ir_write / pc_write / reg_write  output  1 each  register load enables.
REQ-009 SHALL have port alu_src_a  output  1  (0 = PC, 1 = rs).
REQ-010 SHALL have port alu_src_b  output  2  (0 = rt, 1 = const 4, 2 = imm, 3 = imm<<2).
REQ-011 SHALL have port alu_opcode / alu_control  output  6 each  codes driven to the ALU.
REQ-012 SHALL have port reg_dst / mem_to_reg  output  1 each  (1 = rd, 1 = memory data).
REQ-013 SHALL have port pc_source  output  2  (0 = ALU, 1 = ALU_out reg, 2 = jump target).
REQ-014 SHALL have port illegal_op / mem_err  output  1 each  one-cycle error pulses.
REQ-015 SHALL have port state  output  4  current FSM state for debug.

Function
REQ-016 SHALL be a Moore FSM: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, TRAP.
REQ-017 FETCH: mem_req=1, iord=0; on mem_ready, ir_write=1, pc_write=1, alu_opcode=0x09 (addiu), alu_src_a=0, alu_src_b=1 -> DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=3, alu_opcode=0x09 (branch target precompute); next state by opcode.
REQ-019 Opcode 0x00 -> EXEC_R; 0x08/0x09/0x0A/0x0B/0x12/0x13/0x15 -> EXEC_I; 0x23/0x24/0x25/0x30/0x28/0x29/0x2B -> MEM_ADDR; 0x04/0x05 -> BRANCH; 0x02 -> JUMP; any other opcode -> TRAP.
REQ-020 EXEC_R: alu_opcode=0, alu_control=funct, src_a=1, src_b=0 -> WB_R; an unsupported funct (not 0x00,0x02,0x03,0x20-0x25,0x27,0x2A,0x2B) -> TRAP.
REQ-021 EXEC_I: alu_opcode=opcode, src_a=1, src_b=2 -> WB_I.
REQ-022 MEM_ADDR: alu_opcode=opcode, src_a=1, src_b=2; loads -> MEM_RD, stores -> MEM_WR.
REQ-023 MEM_RD/MEM_WR: mem_req=1, iord=1, mem_we=1 in MEM_WR only; on mem_ready, MEM_RD -> WB_MEM and MEM_WR -> FETCH.
REQ-024 WB_R: reg_write=1, reg_dst=1. WB_I: reg_write=1, reg_dst=0. WB_MEM: reg_write=1, mem_to_reg=1. All -> FETCH.
REQ-025 BRANCH: alu_opcode=opcode, src_a=1, src_b=0, pc_source=1; pc_write=sig_branch (same cycle) -> FETCH.
REQ-026 JUMP: pc_source=2, pc_write=1 -> FETCH.
REQ-027 TRAP: illegal_op=1 for exactly one cycle -> FETCH; the PC is not modified.
REQ-028 Memory handshake: mem_req SHALL stay high until mem_ready; a 4-bit wait counter SHALL clear on entry to each memory state.
REQ-029 If mem_ready is still low after MEM_TIMEOUT wait cycles, mem_err SHALL pulse one cycle, mem_req SHALL drop, and the FSM SHALL go to FETCH with no register or PC write.
REQ-030 mem_ready asserted in the first cycle of a memory state SHALL complete that access (zero wait states).
REQ-031 Outputs not named for a state SHALL be 0 in that state; no enable SHALL be high for more than one cycle per access.

Reset
REQ-032 rst_n low SHALL force state=FETCH, wait counter=0, and all outputs to 0 immediately, including mid-access; mem_ready during reset SHALL be ignored.
REQ-033 After release, the first mem_req SHALL assert at the first rising clk edge.

Structure
REQ-034 A shared package mips_pkg SHALL hold the state enum, opcode/funct constants and alu_src_b encodings.
REQ-035 A sub-module mips_mc_decode (combinational: opcode/funct -> class, legal) SHALL be instantiated once.

Verification
REQ-036 add: instr=0x012A4020, mem_ready=1 -> FETCH,DECODE,EXEC_R(alu_control=0x20),WB_R(reg_write=1,reg_dst=1), 4 cycles.
REQ-037 lw: opcode 0x23, mem_ready delayed 3 cycles in MEM_RD -> mem_req high 4 cycles, then WB_MEM with mem_to_reg=1.
REQ-038 beq: opcode 0x04 with sig_branch=1 -> pc_write=1, pc_source=1; with sig_branch=0 -> pc_write=0.
REQ-039 opcode 0x3F -> TRAP, illegal_op pulses 1 cycle, no reg_write.
REQ-040 MEM_WR with mem_ready held low 15 cycles -> mem_err pulse, FETCH, mem_we=0 afterwards.
REQ-041 rst_n low during MEM_RD -> outputs 0 immediately, state=FETCH.
